// File: rtl/mbus_axi_write_bridge.sv
`default_nettype none
// ============================================================================
// mbus_axi_write_bridge
// Converts one granted mbus write burst into one AXI4 INCR write burst.
// Revision: 1.0
// ============================================================================
module mbus_axi_write_bridge #(
   parameter int CTRL_ADDR_WIDTH = 28,
   parameter int MEM_DQ_WIDTH    = 16,
   parameter int BURST_LENGTH    = 8,
   parameter int BURST_BEATS     = 16,
   parameter int RD_LATENCY      = 1,
   parameter int BUF_DEPTH       = 4,
   parameter int GAP_CYCLES      = 3,
   localparam int DW             = MEM_DQ_WIDTH * BURST_LENGTH
) (
   input  logic                       i_axi_aclk,
   input  logic                       i_rst,
   input  logic                       i_mbus_wrq,
   input  logic [CTRL_ADDR_WIDTH-1:0] i_mbus_waddr,
   input  logic [DW-1:0]              i_mbus_wdata,
   input  logic                       i_mbus_wready,
   output logic                       o_mbus_wdata_rq,
   output logic                       o_mbus_wbusy,
   output logic                       o_mbus_wsel,
   output logic [CTRL_ADDR_WIDTH-1:0] o_axi_awaddr,
   output logic [7:0]                 o_axi_awlen,
   output logic                       o_axi_awvalid,
   input  logic                       i_axi_awready,
   output logic [DW-1:0]              o_axi_wdata,
   output logic [DW/8-1:0]            o_axi_wstrb,
   output logic                       o_axi_wlast,
   output logic                       o_axi_wvalid,
   input  logic                       i_axi_wready,
   input  logic [1:0]                 i_axi_bresp,
   input  logic                       i_axi_bvalid,
   output logic                       o_axi_bready,
   output logic                       o_wr_err
);

   localparam int CW = $clog2(BURST_BEATS) + 1;
   localparam int PW = $clog2(BUF_DEPTH);
   localparam int BW = PW + 1;
   localparam int GW = $clog2(GAP_CYCLES) + 1;
   localparam logic [CW-1:0] BEATS_C  = CW'(BURST_BEATS);
   localparam logic [CW-1:0] LAST_C   = CW'(BURST_BEATS - 1);
   localparam logic [BW:0]   DEPTH_C  = (BW + 1)'(BUF_DEPTH);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      GRANT = 3'd1,
      XFER  = 3'd2,
      RESP  = 3'd3,
      GAP   = 3'd4
   } state_t;

   state_t                state;
   logic [CW-1:0]         req_cnt;
   logic [CW-1:0]         beat_cnt;
   logic [GW-1:0]         gap_cnt;
   logic                  aw_done;
   logic                  w_done;
   logic [BW-1:0]         buf_cnt;
   logic [BW-1:0]         inflight;
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [RD_LATENCY-1:0] rq_pipe;
   logic [DW-1:0]         mem [BUF_DEPTH];

   logic                  rq;
   logic                  capture;
   logic                  pop;
   logic                  aw_fire;
   logic                  last_fire;
   logic [BW:0]           occ;

   // Reserve a buffer slot for every read still in flight so a capture can never overflow.
   assign occ       = {1'b0, buf_cnt} + {1'b0, inflight};
   assign rq        = (state == XFER) && (req_cnt < BEATS_C) && (occ < DEPTH_C);
   assign capture   = rq_pipe[RD_LATENCY-1];
   assign pop       = o_axi_wvalid && i_axi_wready;
   assign aw_fire   = o_axi_awvalid && i_axi_awready;
   assign last_fire = pop && o_axi_wlast;

   assign o_mbus_wdata_rq = rq;
   assign o_axi_wvalid    = (buf_cnt != '0);
   assign o_axi_wdata     = o_axi_wvalid ? mem[rd_ptr] : '0;
   assign o_axi_wstrb     = {(DW/8){o_axi_wvalid}};
   assign o_axi_wlast     = o_axi_wvalid && (beat_cnt == LAST_C);

   always_ff @(posedge i_axi_aclk) begin
      if (capture) begin
         mem[wr_ptr] <= i_mbus_wdata;
      end
   end

   always_ff @(posedge i_axi_aclk) begin
      if (i_rst) begin
         rq_pipe  <= '0;
         buf_cnt  <= '0;
         inflight <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else begin
         rq_pipe  <= RD_LATENCY'({rq_pipe, rq});
         inflight <= inflight + BW'(rq) - BW'(capture);
         buf_cnt  <= buf_cnt + BW'(capture) - BW'(pop);
         if (capture) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

   always_ff @(posedge i_axi_aclk) begin
      if (i_rst) begin
         state         <= IDLE;
         o_mbus_wsel   <= 1'b0;
         o_mbus_wbusy  <= 1'b0;
         o_axi_awvalid <= 1'b0;
         o_axi_awaddr  <= '0;
         o_axi_awlen   <= '0;
         o_axi_bready  <= 1'b0;
         o_wr_err      <= 1'b0;
         req_cnt       <= '0;
         beat_cnt      <= '0;
         gap_cnt       <= '0;
         aw_done       <= 1'b0;
         w_done        <= 1'b0;
      end else begin
         o_mbus_wsel <= 1'b0;
         o_wr_err    <= 1'b0;
         if (rq) begin
            req_cnt <= req_cnt + CW'(1);
         end
         if (pop) begin
            beat_cnt <= beat_cnt + CW'(1);
         end
         if (aw_fire) begin
            o_axi_awvalid <= 1'b0;
            aw_done       <= 1'b1;
         end
         if (last_fire) begin
            w_done <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (i_mbus_wrq && i_mbus_wready) begin
                  o_axi_awaddr  <= i_mbus_waddr;
                  o_axi_awlen   <= 8'(BURST_BEATS - 1);
                  o_axi_awvalid <= 1'b1;
                  o_mbus_wsel   <= 1'b1;
                  o_mbus_wbusy  <= 1'b1;
                  aw_done       <= 1'b0;
                  w_done        <= 1'b0;
                  state         <= GRANT;
               end
            end
            GRANT: begin
               req_cnt  <= '0;
               beat_cnt <= '0;
               state    <= XFER;
            end
            XFER: begin
               // AW and the final W beat may complete in either order or together.
               if ((aw_done || aw_fire) && (w_done || last_fire)) begin
                  o_axi_bready <= 1'b1;
                  state        <= RESP;
               end
            end
            RESP: begin
               if (i_axi_bvalid) begin
                  o_axi_bready <= 1'b0;
                  o_mbus_wbusy <= 1'b0;
                  o_wr_err     <= (i_axi_bresp != 2'b00);
                  gap_cnt      <= '0;
                  state        <= GAP;
               end
            end
            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
